// File: rtl/ifc_pkg.sv
// Instruction fetch controller shared definitions: state encoding, reset PC,
// IF slot payload and sequential-PC helper (also used by the exception unit).
package ifc_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } ifc_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } if_slot_t;

    // Sequential successor of a fetch PC, wrapping modulo 2^32.
    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction memory port: request/address handshake plus data return.
interface inst_fetch_ctrl_if;
    import ifc_pkg::*;

    logic            inst_req;
    logic [XLEN-1:0] inst_addr;
    logic            inst_addr_ok;
    logic            inst_data_ok;
    logic [XLEN-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/if_slot_buf.sv
// Single-entry IF slot: holds one fetched word and its PC until decode takes it.
// Priority: flush > write > consume (a write replaces a word consumed that cycle).
module if_slot_buf
    import ifc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     wr_en,
    input  if_slot_t wr_data,
    input  logic     consume,
    output logic     valid,
    output if_slot_t slot
);

    // Slot valid bit and payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            slot  <= '{pc: RESET_PC, inst: '0};
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
            slot  <= wr_data;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, keeps at most one request
// outstanding on the memory port and squashes data returning for redirected PCs.
// Optional build macro IFC_PERF_CNT_EN adds the perf_stall_cnt bubble counter.
module inst_fetch_ctrl
    import ifc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pipe_stall,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    inst_fetch_ctrl_if.master   mem,
    output logic                if_valid,
    output logic [XLEN-1:0]     if_pc,
    output logic [XLEN-1:0]     if_inst,
`ifdef IFC_PERF_CNT_EN
    output logic [XLEN-1:0]     perf_stall_cnt,
`endif
    output logic                fetch_stall
);

    ifc_state_e      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            cancel_q, cancel_d;
    logic            issue_ok;
    logic            req_c;
    logic            slot_wr;
    if_slot_t        slot_q;

    // A request may only go out if the slot is guaranteed free when data returns.
    assign issue_ok = !if_valid || !pipe_stall;

    // Next-state, next fetch PC, cancel flag and slot write decode.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        cancel_d   = cancel_q;
        req_c      = 1'b0;
        slot_wr    = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                req_c = issue_ok;
                if (req_c && mem.inst_addr_ok) begin
                    state_d  = ST_WAIT;
                    cancel_d = redirect;
                end
            end
            ST_WAIT: begin
                if (mem.inst_data_ok) begin
                    state_d  = ST_REQ;
                    cancel_d = 1'b0;
                    if (!cancel_q && !redirect) begin
                        slot_wr    = 1'b1;
                        fetch_pc_d = next_seq_pc(fetch_pc_q);
                    end
                end else if (redirect) begin
                    cancel_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
    end

    // FSM state, fetch PC and in-flight cancel flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            cancel_q   <= cancel_d;
        end
    end

    if_slot_buf #(
        .RESET_PC (RESET_PC)
    ) u_slot (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect),
        .wr_en   (slot_wr),
        .wr_data ('{pc: fetch_pc_q, inst: mem.inst_rdata}),
        .consume (if_valid && !pipe_stall),
        .valid   (if_valid),
        .slot    (slot_q)
    );

    assign mem.inst_req  = req_c;
    assign mem.inst_addr = fetch_pc_q;
    assign if_pc         = slot_q.pc;
    assign if_inst       = slot_q.inst;
    assign fetch_stall   = !if_valid;

`ifdef IFC_PERF_CNT_EN
    // Saturating count of bubble cycles seen by the pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
        end else if (fetch_stall && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: random memory latency, stalls and redirects
// against a program-order reference stream; a monitor checks every consumed word.
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RPC = 32'hbfc0_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_stall;
`ifdef IFC_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    int          perf_model = 0;
`endif

    inst_fetch_ctrl_if mif ();

    inst_fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_stall     (pipe_stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .mem            (mif),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
`ifdef IFC_PERF_CNT_EN
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .fetch_stall    (fetch_stall)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          consumed = 0;
    exp_t        exp_q[$];
    logic [31:0] model_pc = RPC;
    logic [31:0] exp_req_addr = RPC;

    // memory model state and stimulus knobs
    logic        pending = 1'b0;
    logic [31:0] pend_addr = '0;
    int          wait_cnt = 0;
    int          acc_pct = 100, kmin = 1, kmax = 1, stall_pct = 0, redir_pct = 0;
    int          stall_left = 0, stall_seen = 0, hold_left = 0;
    int          redir_mode = 0;
    logic [31:0] redir_tgt = '0;
    logic        redir_fired = 1'b0;
    logic        stall_chk = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 9))
            0:       t = 32'hffff_fff8;
            1:       t = $urandom();
            default: t = $urandom() & 32'hffff_fffc;
        endcase
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Keep the expected program-order stream topped up.
    task automatic refill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc   = model_pc;
            e.inst = mem_word(model_pc);
            exp_q.push_back(e);
            model_pc += 32'd4;
        end
    endtask

    task automatic do_reset(input logic late_data);
        @(negedge clk);
        reset = 1'b1;
        pipe_stall = 1'b0; redirect = 1'b0;
        mif.inst_addr_ok = 1'b0; mif.inst_data_ok = 1'b0; mif.inst_rdata = '0;
        pending = 1'b0;
        exp_q.delete();
        model_pc = RPC;
        exp_req_addr = RPC;
        refill();
        #1;
        chk("rst_inst_req", 32'(mif.inst_req), 32'd0);
        chk("rst_inst_addr", mif.inst_addr, RPC);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, RPC);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_fetch_stall", 32'(fetch_stall), 32'd1);
`ifdef IFC_PERF_CNT_EN
        chk("rst_perf_cnt", perf_stall_cnt, 32'd0);
        perf_model = 1;
`endif
        @(negedge clk);
        reset = 1'b0;
        if (late_data) begin
            mif.inst_data_ok = 1'b1;
            mif.inst_rdata = 32'hdead_beef;
        end
    endtask

    // One clock of stimulus: memory responses, stall, redirect.
    task automatic cycle();
        logic data_now;
        logic do_redir;
        @(negedge clk);
        mif.inst_addr_ok = 1'b0;
        mif.inst_data_ok = 1'b0;
        mif.inst_rdata   = $urandom();
        redirect    = 1'b0;
        redirect_pc = $urandom();
        data_now    = 1'b0;
        if (pending) begin
            if (wait_cnt == 0) begin
                mif.inst_data_ok = 1'b1;
                mif.inst_rdata   = mem_word(pend_addr);
                pending  = 1'b0;
                data_now = 1'b1;
            end else begin
                wait_cnt--;
            end
        end
        if (stall_left > 0 && if_valid) begin
            pipe_stall = 1'b1;
            stall_left--;
        end else begin
            pipe_stall = ($urandom_range(0, 99) < stall_pct);
        end
        case (redir_mode)
            0:       do_redir = ($urandom_range(0, 99) < redir_pct);
            1:       do_redir = data_now;
            2:       do_redir = pending;
            default: do_redir = 1'b1;
        endcase
        #1;
        if (stall_chk && pipe_stall && if_valid && exp_q.size() > 0) begin
            stall_seen++;
            chk("stall_inst_req", 32'(mif.inst_req), 32'd0);
            chk("stall_if_pc", if_pc, exp_q[0].pc);
            chk("stall_if_inst", if_inst, exp_q[0].inst);
        end
        if (mif.inst_req) begin
            chk("inst_addr", mif.inst_addr, exp_req_addr);
        end
        if (mif.inst_req && !pending) begin
            if (hold_left > 0) begin
                hold_left--;
            end else if ($urandom_range(0, 99) < acc_pct) begin
                mif.inst_addr_ok = 1'b1;
                pending   = 1'b1;
                pend_addr = mif.inst_addr;
                wait_cnt  = $urandom_range(kmin, kmax) - 1;
                exp_req_addr += 32'd4;
            end
        end
        if (do_redir) begin
            redirect    = 1'b1;
            redirect_pc = (redir_mode != 0) ? redir_tgt : rand_target();
            exp_req_addr = redirect_pc;
            exp_q.delete();
            model_pc    = redirect_pc;
            redir_mode  = 0;
            redir_fired = 1'b1;
        end
`ifdef IFC_PERF_CNT_EN
        chk("perf_cnt", perf_stall_cnt, 32'(perf_model));
        if (!if_valid) perf_model++;
`endif
        refill();
    endtask

    // Monitor: every word decode takes must be the next one in program order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && !redirect && if_valid && !pipe_stall) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_inst", if_inst, e.inst);
                    consumed++;
                end
            end
        end
    end

    initial begin
        mif.inst_addr_ok = 1'b0;
        mif.inst_data_ok = 1'b0;
        mif.inst_rdata   = '0;
        do_reset(1'b0);

        // back-to-back fetch with one-cycle memory: slot valid every other cycle
        for (int i = 0; i < 14; i++) begin
            cycle();
            chk("if_valid_seq", 32'(if_valid), 32'((i >= 2) && (i % 2 == 0)));
        end

        // decode stalled for five cycles with a full slot
        stall_chk = 1'b1;
        stall_left = 5;
        for (int i = 0; i < 12 && stall_left > 0; i++) cycle();
        chk("stall_cycles", 32'(stall_seen), 32'd5);
        stall_chk = 1'b0;

        // address handshake withheld for three cycles
        hold_left = 3;
        for (int i = 0; i < 12; i++) cycle();
        chk("addr_hold_done", 32'(hold_left), 32'd0);

        // redirect while waiting for data (data two cycles later)
        kmin = 3; kmax = 3;
        redir_fired = 1'b0; redir_mode = 2; redir_tgt = 32'h8000_1000;
        for (int i = 0; i < 14; i++) cycle();
        chk("redir_wait_fired", 32'(redir_fired), 32'd1);

        // redirect in the same cycle as data return
        kmin = 1; kmax = 1;
        redir_fired = 1'b0; redir_mode = 1; redir_tgt = 32'h8000_1000;
        for (int i = 0; i < 14; i++) cycle();
        chk("redir_data_fired", 32'(redir_fired), 32'd1);

        // fetch PC wraps past the top of the address space
        redir_fired = 1'b0; redir_mode = 3; redir_tgt = 32'hffff_fff8;
        for (int i = 0; i < 14; i++) cycle();
        chk("redir_wrap_fired", 32'(redir_fired), 32'd1);

        // randomized traffic with a mid-run reset and a stale data return
        acc_pct = 70; kmin = 1; kmax = 4; stall_pct = 30; redir_pct = 4;
        for (int i = 0; i < 1500; i++) cycle();
        do_reset(1'b1);
        for (int i = 0; i < 1500; i++) cycle();

        chk("liveness", 32'(consumed > 300), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
